letc_core_stage_fetch1: RTL and testbench
=========================================

LETC_CORE_STAGE_FETCH1 -- requirements
Module: letc_core_stage_fetch1

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset; bits [1:0] are treated as zero.
REQ-002 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port f2_ready  input  1  fetch 2 can accept a new fetch this cycle.
REQ-005 SHALL have port f1_stall  input  1  hazard unit holds fetch 1.
REQ-006 SHALL have port f1_flush  input  1  kill any fetch issued this cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/trap redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] are ignored.
REQ-009 SHALL have port halt_req  input  1  stop fetching (WFI/fence) after the current cycle.
REQ-010 SHALL have port imss_req_valid  output  1  instruction fetch request to the IMSS.
REQ-011 SHALL have port imss_req_addr  output  32  fetch address, word aligned.
REQ-012 SHALL have port f1_to_f2_valid  output  1  fetch issued to fetch 2.
REQ-013 SHALL have port f1_to_f2_pc  output  32  PC of the issued fetch.
REQ-014 SHALL have port f1_halted  output  1  FSM is in HALTED.

Function
REQ-015 SHALL hold a 32-bit PC register pc_q, with pc_q[1:0] always 2'b00.
REQ-016 SHALL implement the FSM states BOOT, RUN and HALTED.
REQ-017 BOOT SHALL last exactly one cycle after rst deasserts, issue nothing, then go to RUN.
REQ-018 issue SHALL equal (state==RUN) & f2_ready & !f1_stall & !f1_flush & !redirect_valid.
REQ-019 imss_req_valid and f1_to_f2_valid SHALL both equal issue, combinationally, in the same cycle.
REQ-020 imss_req_addr and f1_to_f2_pc SHALL both equal pc_q, including in cycles where issue is 0.
REQ-021 On issue, pc_q SHALL become pc_q+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 redirect_valid SHALL take priority over every other event in any state, including BOOT.
  - pc_q <= {redirect_pc[31:2],2'b00}
  - no issue that cycle
  - next state RUN
REQ-023 A redirect SHALL therefore cost exactly one bubble cycle.
REQ-024 While f1_stall, !f2_ready or f1_flush (and no redirect), pc_q and the state SHALL hold.
REQ-025 halt_req in RUN with no redirect SHALL move the FSM to HALTED next cycle; an issue in that same cycle still completes and pc_q advances.
REQ-026 In HALTED, no request SHALL be issued and pc_q SHALL hold; only redirect_valid exits, to RUN.
REQ-027 halt_req outside RUN SHALL be ignored.
REQ-028 f1_halted SHALL be 1 iff the state is HALTED.

Reset
REQ-029 While rst=1, the state SHALL be BOOT, pc_q SHALL be RESET_PC with [1:0] zeroed, and all valid outputs and f1_halted SHALL be 0, asynchronously.
REQ-030 rst asserted mid-operation SHALL drop imss_req_valid and f1_to_f2_valid immediately, without waiting for a clock edge, and discard any pending redirect or halt.

Verification
REQ-031 Bench SHALL cover boot: RESET_PC=32'h8000_0000, release rst, f2_ready=1 -> cycle 0 no valid; cycles 1..3 issue 8000_0000, 8000_0004, 8000_0008.
REQ-032 Bench SHALL cover backpressure: f2_ready=0 for 3 cycles mid-stream at pc 0x10 -> no valid for 3 cycles; next issue is 0x10; no address skipped or duplicated.
REQ-033 Bench SHALL cover redirect: redirect_valid with redirect_pc=32'h0000_1003 while stalled -> that cycle no valid; next unstalled issue is 0x1000.
REQ-034 Bench SHALL cover wrap: redirect to 0xFFFF_FFFC -> issues FFFF_FFFC then 0000_0000.
REQ-035 Bench SHALL cover halt: halt_req at pc 0x20 with issue -> 0x20 issued; f1_halted=1 next cycle; no valid for 10 cycles; redirect to 0x40 -> one bubble, then 0x40 issued, f1_halted=0.
REQ-036 Bench SHALL cover reset mid-run: assert rst between clock edges while valid=1 -> valid drops at once; after release the BOOT bubble recurs and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/letc_core_stage_fetch1.sv
`default_nettype none
// ============================================================================
// Module      : letc_core_stage_fetch1
// Description : Fetch stage 1. Holds the PC, issues word-aligned fetches to
//               the IMSS and fetch 2, and handles redirects and halts.
// Revision    : 1.0 - initial release
// ============================================================================
module letc_core_stage_fetch1 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f2_ready,
    input  logic        f1_stall,
    input  logic        f1_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        imss_req_valid,
    output logic [31:0] imss_req_addr,
    output logic        f1_to_f2_valid,
    output logic [31:0] f1_to_f2_pc,
    output logic        f1_halted
);

    localparam logic [1:0]  c_st_boot   = 2'd0;
    localparam logic [1:0]  c_st_run    = 2'd1;
    localparam logic [1:0]  c_st_halted = 2'd2;
    localparam logic [31:0] c_align     = 32'hFFFF_FFFC;
    localparam logic [31:0] c_reset_pc  = RESET_PC & c_align;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        w_issue;

    // A redirect in the same cycle always suppresses the issue: it costs one bubble.
    assign w_issue = (r_state == c_st_run) & f2_ready & ~f1_stall & ~f1_flush & ~redirect_valid;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (redirect_valid) begin
            w_pc_next    = redirect_pc & c_align;
            w_state_next = c_st_run;
        end else begin
            case (r_state)
                c_st_boot: begin
                    w_state_next = c_st_run;
                end
                c_st_run: begin
                    if (w_issue) begin
                        w_pc_next = r_pc + 32'd4;
                    end
                    if (halt_req) begin
                        w_state_next = c_st_halted;
                    end
                end
                c_st_halted: begin
                    w_state_next = c_st_halted;
                end
                default: begin
                    w_state_next = c_st_boot;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_boot;
            r_pc    <= c_reset_pc;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign imss_req_valid = w_issue;
    assign f1_to_f2_valid = w_issue;
    assign imss_req_addr  = r_pc;
    assign f1_to_f2_pc    = r_pc;
    assign f1_halted      = (r_state == c_st_halted);

endmodule
`default_nettype wire

// File: tb/tb_letc_core_stage_fetch1.sv
`default_nettype none
// ============================================================================
// Module      : tb_letc_core_stage_fetch1
// Description : Self-checking bench for fetch stage 1 with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_letc_core_stage_fetch1;

    localparam logic [31:0] c_reset_pc_param = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        f2_ready;
    logic        f1_stall;
    logic        f1_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        imss_req_valid;
    logic [31:0] imss_req_addr;
    logic        f1_to_f2_valid;
    logic [31:0] f1_to_f2_pc;
    logic        f1_halted;

    letc_core_stage_fetch1 #(.RESET_PC(c_reset_pc_param)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .f2_ready       (f2_ready),
        .f1_stall       (f1_stall),
        .f1_flush       (f1_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imss_req_valid (imss_req_valid),
        .imss_req_addr  (imss_req_addr),
        .f1_to_f2_valid (f1_to_f2_valid),
        .f1_to_f2_pc    (f1_to_f2_pc),
        .f1_halted      (f1_halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: "booting" = one dead cycle pending, "halted" = parked.
    bit          m_booting;
    bit          m_halted;
    longint      m_pc;
    logic [31:0] issued[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_issue();
        return !m_booting && !m_halted && f2_ready && !f1_stall && !f1_flush && !redirect_valid;
    endfunction

    task automatic idle_inputs();
        f2_ready       = 1'b1;
        f1_stall       = 1'b0;
        f1_flush       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance the model across the rising edge.
    task automatic cycle();
        bit iss;
        @(negedge clk);
        iss = model_issue();
        check("imss_req_valid", {31'b0, imss_req_valid}, {31'b0, iss});
        check("f1_to_f2_valid", {31'b0, f1_to_f2_valid}, {31'b0, iss});
        check("imss_req_addr", imss_req_addr, m_pc[31:0]);
        check("f1_to_f2_pc", f1_to_f2_pc, m_pc[31:0]);
        check("f1_halted", {31'b0, f1_halted}, {31'b0, m_halted});
        if (imss_req_valid) issued.push_back(imss_req_addr);
        @(posedge clk);
        if (redirect_valid) begin
            m_pc      = longint'(redirect_pc) / 4 * 4;
            m_booting = 1'b0;
            m_halted  = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_halted) begin
            if (iss) m_pc = (m_pc + 4) % (64'd1 << 32);
            if (halt_req) m_halted = 1'b1;
        end
        #1;
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_halted  = 1'b0;
        m_pc      = longint'(c_reset_pc_param) / 4 * 4;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_valid"}, {30'b0, imss_req_valid, f1_to_f2_valid}, 32'h0);
        check({tag, "_halted"}, {31'b0, f1_halted}, 32'h0);
        check({tag, "_addr"}, imss_req_addr, c_reset_pc_param & 32'hFFFF_FFFC);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_in_reset("reset");
        rst = 1'b0;

        // Boot: one dead cycle, then sequential fetch from RESET_PC.
        issued.delete();
        repeat (4) cycle();
        check("boot_count", 32'(issued.size()), 32'd3);
        if (issued.size() >= 3) begin
            check("boot_pc0", issued[0], 32'h8000_0000);
            check("boot_pc1", issued[1], 32'h8000_0004);
            check("boot_pc2", issued[2], 32'h8000_0008);
        end

        // Backpressure at 0x10.
        redirect_to(32'h0000_0010);
        issued.delete();
        f2_ready = 1'b0;
        repeat (3) cycle();
        check("bp_none", 32'(issued.size()), 32'd0);
        f2_ready = 1'b1;
        repeat (2) cycle();
        check("bp_count", 32'(issued.size()), 32'd2);
        if (issued.size() >= 2) begin
            check("bp_pc0", issued[0], 32'h0000_0010);
            check("bp_pc1", issued[1], 32'h0000_0014);
        end

        // Redirect while stalled to a misaligned target.
        issued.delete();
        f1_stall = 1'b1;
        redirect_to(32'h0000_1003);
        f1_stall = 1'b0;
        cycle();
        check("redir_count", 32'(issued.size()), 32'd1);
        if (issued.size() >= 1) check("redir_pc", issued[0], 32'h0000_1000);

        // PC wrap.
        redirect_to(32'hFFFF_FFFC);
        issued.delete();
        repeat (2) cycle();
        check("wrap_count", 32'(issued.size()), 32'd2);
        if (issued.size() >= 2) begin
            check("wrap_pc0", issued[0], 32'hFFFF_FFFC);
            check("wrap_pc1", issued[1], 32'h0000_0000);
        end

        // Halt at 0x20, sit halted, redirect out to 0x40.
        redirect_to(32'h0000_0020);
        issued.delete();
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        check("halt_issue", 32'(issued.size()), 32'd1);
        if (issued.size() >= 1) check("halt_pc", issued[0], 32'h0000_0020);
        check("halt_flag", {31'b0, f1_halted}, 32'd1);
        repeat (10) cycle();
        check("halt_quiet", 32'(issued.size()), 32'd1);
        redirect_to(32'h0000_0040);
        check("unhalt_flag", {31'b0, f1_halted}, 32'd0);
        cycle();
        check("unhalt_count", 32'(issued.size()), 32'd2);
        if (issued.size() >= 2) check("unhalt_pc", issued[1], 32'h0000_0040);

        // Reset asserted between edges while a fetch is valid.
        #2;
        check("pre_rst_valid", {31'b0, imss_req_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_in_reset("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issued.delete();
        repeat (2) cycle();
        check("rst_boot_count", 32'(issued.size()), 32'd1);
        if (issued.size() >= 1) check("rst_boot_pc", issued[0], 32'h8000_0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            f2_ready       = ($urandom % 4) != 0;
            f1_stall       = ($urandom % 5) == 0;
            f1_flush       = ($urandom % 8) == 0;
            redirect_valid = ($urandom % 14) == 0;
            redirect_pc    = $urandom;
            halt_req       = ($urandom % 12) == 0;
            cycle();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
